// File: rtl/pci_rr_arbiter.sv
// pci_rr_arbiter: round-robin PCI bus arbiter with request masking, bus parking,
// a guaranteed all-high GNT gap on ownership change and revocation of idle grantees.
// Ports: PCLK / RST_N (async active-low) clock and reset; REQ_N / GNT_N per-master
// active-low request and grant; FRAME_N / IRDY_N sampled bus signals; arb_enable,
// req_mask control; owner, bus_idle, timeout_pulse, timeout_id status.
module pci_rr_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int PARK_EN      = 1,
    parameter int PARK_MASTER  = 0,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                           PCLK,
    input  logic                           RST_N,
    input  logic [NUM_MASTERS-1:0]         REQ_N,
    input  logic                           FRAME_N,
    input  logic                           IRDY_N,
    output logic [NUM_MASTERS-1:0]         GNT_N,
    input  logic                           arb_enable,
    input  logic [NUM_MASTERS-1:0]         req_mask,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           bus_idle,
    output logic                           timeout_pulse,
    output logic [$clog2(NUM_MASTERS)-1:0] timeout_id
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam logic [IW-1:0] PARK_IDX = IW'(PARK_MASTER);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);
    localparam logic [7:0]    TMO_LAST = 8'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_GAP} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] req_q, req_d, gnt_n_q, gnt_n_d;
    logic                   frame_q, frame_d, irdy_q, irdy_d;
    logic                   bus_idle_q, bus_idle_d, parked_q, parked_d;
    logic                   tmo_pulse_q, tmo_pulse_d;
    logic [IW-1:0]          owner_q, owner_d, last_q, last_d, tmo_id_q, tmo_id_d;
    logic [IW-1:0]          pick, cand;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] elig, own_oh;
    logic                   idle_q, start;

    function automatic int wrap(input int v);
        return (v >= NUM_MASTERS) ? v - NUM_MASTERS : v;
    endfunction

    assign elig   = ~req_q & ~req_mask;
    assign idle_q = frame_q & irdy_q;
    // bus_idle_q is idle_q one cycle later, so this flags the first non-idle cycle
    assign start  = ~frame_q & bus_idle_q;
    assign own_oh = NUM_MASTERS'(1) << owner_q;

    assign GNT_N         = gnt_n_q;
    assign owner         = owner_q;
    assign bus_idle      = bus_idle_q;
    assign timeout_pulse = tmo_pulse_q;
    assign timeout_id    = tmo_id_q;

    // Scan downward so the eligible master closest after last_q is the final assignment
    always_comb begin
        pick = last_q;
        cand = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            cand = IW'(wrap(int'(last_q) + i));
            if (elig[cand]) pick = cand;
        end
    end

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            gnt_n_q     <= '1;
            owner_q     <= '0;
            last_q      <= LAST_RST;
            parked_q    <= 1'b0;
            bus_idle_q  <= 1'b0;
            tmo_pulse_q <= 1'b0;
            tmo_id_q    <= '0;
            cnt_q       <= '0;
            req_q       <= '1;
            frame_q     <= 1'b1;
            irdy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_n_q     <= gnt_n_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            parked_q    <= parked_d;
            bus_idle_q  <= bus_idle_d;
            tmo_pulse_q <= tmo_pulse_d;
            tmo_id_q    <= tmo_id_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            frame_q     <= frame_d;
            irdy_q      <= irdy_d;
        end
    end

    always_comb begin
        req_d       = REQ_N;
        frame_d     = FRAME_N;
        irdy_d      = IRDY_N;
        bus_idle_d  = idle_q;
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        parked_d    = parked_q;
        cnt_d       = cnt_q;
        tmo_pulse_d = 1'b0;
        tmo_id_d    = tmo_id_q;
        case (state_q)
            S_IDLE: begin
                if (elig != '0 && arb_enable) begin
                    state_d  = S_GRANT;
                    owner_d  = pick;
                    last_d   = pick;
                    parked_d = 1'b0;
                    cnt_d    = '0;
                end else if (PARK_EN != 0 && arb_enable) begin
                    state_d  = S_GRANT;
                    owner_d  = PARK_IDX;
                    parked_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            S_GRANT: begin
                if (!arb_enable) state_d = S_GAP;
                else if (start) state_d = S_BUSY;
                else if (parked_q && elig != '0) state_d = S_GAP;
                else if (!parked_q && !elig[owner_q]) state_d = S_GAP;
                else if (!parked_q && idle_q && cnt_q == TMO_LAST) begin
                    state_d     = S_GAP;
                    tmo_pulse_d = 1'b1;
                    tmo_id_d    = owner_q;
                end else if (idle_q) cnt_d = cnt_q + 8'd1;
            end
            S_BUSY: begin
                // Hidden arbitration: drop GNT while the running transaction finishes
                if (!arb_enable || (elig & ~own_oh) != '0) state_d = S_GAP;
                else if (idle_q) begin
                    state_d = S_GRANT;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_n_d = (state_d == S_GRANT || state_d == S_BUSY) ? ~(NUM_MASTERS'(1) << owner_d) : '1;
    end
endmodule
